// File: rtl/barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shifter_pipe
//
// Pipelined barrel shifter with four shift modes (rotate-left, logical-left,
// logical-right, arithmetic-right) and a carry output holding the last bit
// shifted out.
//
// The shifter is built from SW = log2(WIDTH) mux levels. Level i shifts by
// 2^i when bit i of the shift amount is set. REG_EVERY consecutive levels
// form one pipeline stage, so the latency is LAT = ceil(SW / REG_EVERY).
// Each stage register carries data, shift amount, mode, valid and the
// running carry.
//
// A single global enable drives every stage. The pipe advances whenever the
// output register is empty or being consumed. Bubbles travel through the
// pipe and are never squeezed out.
//
// Ports
//   in_clk    clock, rising edge
//   in_rst    asynchronous active-high reset
//   in_valid  operand valid
//   ou_ready  shifter accepts an operand this cycle (equals the enable)
//   in_a      operand, WIDTH bits
//   in_s      shift amount, SW bits
//   in_m      mode: 00 ROL, 01 LSL, 10 LSR, 11 ASR
//   ou_valid  result valid
//   in_ready  downstream accepts the result
//   ou_z      shifted result, WIDTH bits
//   ou_c      carry: last bit shifted out (0 when the shift amount is 0)
// -----------------------------------------------------------------------------
module barrel_shifter_pipe #(
  parameter  int WIDTH     = 8,
  parameter  int REG_EVERY = 1,
  localparam int SW        = $clog2(WIDTH)
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_valid,
  output logic             ou_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [SW-1:0]    in_s,
  input  logic [1:0]       in_m,
  output logic             ou_valid,
  input  logic             in_ready,
  output logic [WIDTH-1:0] ou_z,
  output logic             ou_c
);

  localparam int LAT = (SW + REG_EVERY - 1) / REG_EVERY;

  localparam logic [1:0] MODE_ROL = 2'b00;
  localparam logic [1:0] MODE_LSL = 2'b01;
  localparam logic [1:0] MODE_LSR = 2'b10;
  localparam logic [1:0] MODE_ASR = 2'b11;

  // One mux level: shift d by 2^lvl in mode m. The returned carry is the
  // last bit that crosses the word edge; for ROL this is the bit landing
  // in position 0. Returns {carry, data}.
  function automatic logic [WIDTH:0] level_step(
    input logic [WIDTH-1:0] d,
    input logic             c,
    input logic [1:0]       m,
    input int               lvl
  );
    int               amt;
    logic [WIDTH-1:0] hi_t;
    logic [WIDTH-1:0] lo_t;
    logic [WIDTH-1:0] r_d;
    logic             r_c;
    amt  = 1 << lvl;
    // Bit WIDTH-amt (leaves on a left shift) and bit amt-1 (leaves on a
    // right shift) moved to position 0.
    hi_t = d >> (WIDTH - amt);
    lo_t = d >> (amt - 1);
    case (m)
      MODE_ROL: begin
        r_d = (d << amt) | (d >> (WIDTH - amt));
        r_c = hi_t[0];
      end
      MODE_LSL: begin
        r_d = d << amt;
        r_c = hi_t[0];
      end
      MODE_LSR: begin
        r_d = d >> amt;
        r_c = lo_t[0];
      end
      MODE_ASR: begin
        r_d = $unsigned($signed(d) >>> amt);
        r_c = lo_t[0];
      end
      default: begin
        r_d = d;
        r_c = c;
      end
    endcase
    return {r_c, r_d};
  endfunction

  logic [WIDTH-1:0] data_r     [LAT];
  logic [SW-1:0]    amt_r      [LAT];
  logic [1:0]       mode_r     [LAT];
  logic             valid_r    [LAT];
  logic             carry_r    [LAT];
  logic [WIDTH-1:0] data_nxt_s [LAT];
  logic             carry_nxt_s[LAT];
  logic             en_s;

  assign en_s     = ~valid_r[LAT-1] | in_ready;
  assign ou_ready = en_s;
  assign ou_valid = valid_r[LAT-1];
  assign ou_z     = data_r[LAT-1];
  assign ou_c     = carry_r[LAT-1];

  // Per-stage mux levels: stage j applies levels j*REG_EVERY upward to its input.
  always_comb begin
    logic [WIDTH-1:0] work_d;
    logic             work_c;
    logic [SW-1:0]    work_s;
    logic [1:0]       work_m;
    logic [SW-1:0]    bits;
    logic [WIDTH:0]   step;
    logic             take;
    work_d = '0;
    work_c = 1'b0;
    work_s = '0;
    work_m = 2'b00;
    bits   = '0;
    step   = '0;
    take   = 1'b0;
    for (int j = 0; j < LAT; j++) begin
      if (j == 0) begin
        work_d = in_a;
        work_c = 1'b0;
        work_s = in_s;
        work_m = in_m;
      end else begin
        work_d = data_r[(j > 0) ? j - 1 : 0];
        work_c = carry_r[(j > 0) ? j - 1 : 0];
        work_s = amt_r[(j > 0) ? j - 1 : 0];
        work_m = mode_r[(j > 0) ? j - 1 : 0];
      end
      for (int l = 0; l < SW; l++) begin
        bits   = work_s >> l;
        step   = level_step(work_d, work_c, work_m, l);
        // A level belongs to exactly one stage; levels whose amount bit is
        // clear pass data and carry through untouched.
        take   = ((l / REG_EVERY) == j) && bits[0];
        work_d = take ? step[WIDTH-1:0] : work_d;
        work_c = take ? step[WIDTH]     : work_c;
      end
      data_nxt_s[j]  = work_d;
      carry_nxt_s[j] = work_c;
    end
  end

  // Stage registers: cleared by reset, all advance together on the enable.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int j = 0; j < LAT; j++) begin
        data_r[j]  <= '0;
        amt_r[j]   <= '0;
        mode_r[j]  <= 2'b00;
        valid_r[j] <= 1'b0;
        carry_r[j] <= 1'b0;
      end
    end else if (en_s) begin
      for (int j = 0; j < LAT; j++) begin
        data_r[j]  <= data_nxt_s[j];
        carry_r[j] <= carry_nxt_s[j];
        if (j == 0) begin
          valid_r[j] <= in_valid;
          amt_r[j]   <= in_s;
          mode_r[j]  <= in_m;
        end else begin
          valid_r[j] <= valid_r[(j > 0) ? j - 1 : 0];
          amt_r[j]   <= amt_r[(j > 0) ? j - 1 : 0];
          mode_r[j]  <= mode_r[(j > 0) ? j - 1 : 0];
        end
      end
    end
  end

endmodule
